// File: rtl/wb_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_scheduler
// Description : Issue-stage write-back slot scheduler with RegDst select and
//               RAW / WAW / write-port hazard stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_scheduler #(
    parameter int ADDR_W  = 5,
    parameter int MAX_LAT = 4,
    parameter int LAT_W   = 3,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [ADDR_W-1:0] issue_rs_i,
    input  logic [ADDR_W-1:0] issue_rt_i,
    input  logic [ADDR_W-1:0] issue_rd_i,
    input  logic              issue_use_rs_i,
    input  logic              issue_use_rt_i,
    input  logic              issue_regdst_i,
    input  logic              issue_regwrite_i,
    input  logic [LAT_W-1:0]  issue_lat_i,
    output logic [ADDR_W-1:0] dest_o,
    output logic              wb_valid_o,
    output logic [ADDR_W-1:0] wb_dest_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [LAT_W-1:0] c_max_lat = LAT_W'(MAX_LAT);

    logic [MAX_LAT-1:0] r_slot_valid;
    logic [ADDR_W-1:0]  r_slot_dest [MAX_LAT];
    logic [MAX_LAT-1:0] w_nxt_valid;
    logic [ADDR_W-1:0]  w_nxt_dest  [MAX_LAT];
    logic [LAT_W-1:0]   w_leff;
    logic               w_eff_write;
    logic               w_raw;
    logic               w_waw;
    logic               w_struct;
    logic               w_accept;
    logic [CNT_W-1:0]   r_stall_cnt;

    always_comb begin
        if (issue_lat_i == '0) begin
            w_leff = LAT_W'(1);
        end else if (issue_lat_i > c_max_lat) begin
            w_leff = c_max_lat;
        end else begin
            w_leff = issue_lat_i;
        end
    end

    assign dest_o      = issue_regdst_i ? issue_rd_i : issue_rt_i;
    assign w_eff_write = issue_regwrite_i && (dest_o != '0);

    // Slot 0 is written this cycle and forwarded by the register file, so only
    // slots 1..MAX_LAT-1 can block issue.
    always_comb begin
        w_raw    = 1'b0;
        w_waw    = 1'b0;
        w_struct = 1'b0;
        for (int k = 1; k < MAX_LAT; k++) begin
            if (r_slot_valid[k]) begin
                if (issue_use_rs_i && (issue_rs_i != '0) && (issue_rs_i == r_slot_dest[k])) begin
                    w_raw = 1'b1;
                end
                if (issue_use_rt_i && (issue_rt_i != '0) && (issue_rt_i == r_slot_dest[k])) begin
                    w_raw = 1'b1;
                end
                if (w_eff_write && (dest_o == r_slot_dest[k])) begin
                    w_waw = 1'b1;
                end
                if (w_eff_write && (w_leff == LAT_W'(k))) begin
                    w_struct = 1'b1;
                end
            end
        end
    end

    assign issue_ready_o = !flush_i && !w_raw && !w_waw && !w_struct;
    assign w_accept      = issue_valid_i && issue_ready_o;

    // Invalid slots always carry dest 0, so shifting dest unconditionally is safe.
    always_comb begin
        w_nxt_valid = '0;
        for (int k = 0; k < MAX_LAT; k++) begin
            w_nxt_dest[k] = '0;
        end
        for (int k = 0; k < MAX_LAT - 1; k++) begin
            w_nxt_valid[k] = r_slot_valid[k+1];
            w_nxt_dest[k]  = r_slot_dest[k+1];
        end
        if (w_accept && w_eff_write) begin
            for (int k = 0; k < MAX_LAT; k++) begin
                if (w_leff == LAT_W'(k + 1)) begin
                    w_nxt_valid[k] = 1'b1;
                    w_nxt_dest[k]  = dest_o;
                end
            end
        end
        if (flush_i) begin
            w_nxt_valid = '0;
            for (int k = 0; k < MAX_LAT; k++) begin
                w_nxt_dest[k] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_slot_valid <= '0;
            for (int k = 0; k < MAX_LAT; k++) begin
                r_slot_dest[k] <= '0;
            end
        end else begin
            r_slot_valid <= w_nxt_valid;
            for (int k = 0; k < MAX_LAT; k++) begin
                r_slot_dest[k] <= w_nxt_dest[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if (issue_valid_i && !issue_ready_o && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign wb_valid_o  = r_slot_valid[0];
    assign wb_dest_o   = r_slot_dest[0];
    assign busy_o      = |r_slot_valid;
    assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_scheduler
// Description : Directed bench for wb_port_scheduler with a reservation-list
//               reference model checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_scheduler;

    localparam int ADDR_W  = 5;
    localparam int MAX_LAT = 4;
    localparam int LAT_W   = 3;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              flush_i = 1'b0;
    logic              issue_valid_i = 1'b0;
    logic              issue_ready_o;
    logic [ADDR_W-1:0] issue_rs_i = '0;
    logic [ADDR_W-1:0] issue_rt_i = '0;
    logic [ADDR_W-1:0] issue_rd_i = '0;
    logic              issue_use_rs_i = 1'b0;
    logic              issue_use_rt_i = 1'b0;
    logic              issue_regdst_i = 1'b0;
    logic              issue_regwrite_i = 1'b0;
    logic [LAT_W-1:0]  issue_lat_i = '0;
    logic [ADDR_W-1:0] dest_o;
    logic              wb_valid_o;
    logic [ADDR_W-1:0] wb_dest_o;
    logic              busy_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    wb_port_scheduler #(
        .ADDR_W (ADDR_W),
        .MAX_LAT(MAX_LAT),
        .LAT_W  (LAT_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .issue_valid_i   (issue_valid_i),
        .issue_ready_o   (issue_ready_o),
        .issue_rs_i      (issue_rs_i),
        .issue_rt_i      (issue_rt_i),
        .issue_rd_i      (issue_rd_i),
        .issue_use_rs_i  (issue_use_rs_i),
        .issue_use_rt_i  (issue_use_rt_i),
        .issue_regdst_i  (issue_regdst_i),
        .issue_regwrite_i(issue_regwrite_i),
        .issue_lat_i     (issue_lat_i),
        .dest_o          (dest_o),
        .wb_valid_o      (wb_valid_o),
        .wb_dest_o       (wb_dest_o),
        .busy_o          (busy_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // Reference model: each pending write is a destination plus the absolute
    // cycle in which it appears on the write port.
    typedef struct {
        int dest;
        int due;
    } res_t;

    res_t pend[$];
    int   cyc = 0;
    int   m_stall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_leff();
        if (issue_lat_i == 0) return 1;
        if (int'(issue_lat_i) > MAX_LAT) return MAX_LAT;
        return int'(issue_lat_i);
    endfunction

    function automatic int m_dest();
        return issue_regdst_i ? int'(issue_rd_i) : int'(issue_rt_i);
    endfunction

    function automatic bit m_eff();
        return issue_regwrite_i && (m_dest() != 0);
    endfunction

    function automatic bit m_ready();
        bit hz;
        int k;
        hz = 1'b0;
        foreach (pend[i]) begin
            k = pend[i].due - cyc;
            if (k >= 1) begin
                if (issue_use_rs_i && issue_rs_i != 0 && int'(issue_rs_i) == pend[i].dest) hz = 1'b1;
                if (issue_use_rt_i && issue_rt_i != 0 && int'(issue_rt_i) == pend[i].dest) hz = 1'b1;
                if (m_eff() && m_dest() == pend[i].dest) hz = 1'b1;
                // another write already owns the write-back cycle we would need
                if (m_eff() && k == m_leff()) hz = 1'b1;
            end
        end
        return !flush_i && !hz;
    endfunction

    res_t r_new;
    res_t keep[$];

    always @(posedge clk_i) begin
        if (!rst_i) begin
            pend.delete();
            m_stall = 0;
        end else begin
            if (issue_valid_i && !m_ready() && m_stall < CNT_MAX) m_stall++;
            if (flush_i) begin
                keep.delete();
                foreach (pend[i]) if (pend[i].due <= cyc) keep.push_back(pend[i]);
                pend = keep;
            end else if (issue_valid_i && m_ready() && m_eff()) begin
                r_new.dest = m_dest();
                r_new.due  = cyc + m_leff();
                pend.push_back(r_new);
            end
        end
        cyc++;
        keep.delete();
        foreach (pend[i]) if (pend[i].due >= cyc) keep.push_back(pend[i]);
        pend = keep;
    end

    always @(negedge clk_i) begin
        if (mon_en) begin
            if (!rst_i) begin
                check("rst_wb_valid", wb_valid_o, 0);
                check("rst_wb_dest", wb_dest_o, 0);
                check("rst_busy", busy_o, 0);
                check("rst_stall_cnt", stall_cnt_o, 0);
            end else begin : b_cmp
                bit exp_v;
                int exp_d;
                exp_v = 1'b0;
                exp_d = 0;
                foreach (pend[i]) begin
                    if (pend[i].due == cyc) begin
                        exp_v = 1'b1;
                        exp_d = pend[i].dest;
                    end
                end
                check("wb_valid", wb_valid_o, exp_v);
                if (exp_v) check("wb_dest", wb_dest_o, exp_d);
                check("busy", busy_o, pend.size() != 0);
                check("stall_cnt", stall_cnt_o, m_stall);
                check("issue_ready", issue_ready_o, m_ready());
                check("dest", dest_o, m_dest());
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid_i    = 1'b0;
        issue_use_rs_i   = 1'b0;
        issue_use_rt_i   = 1'b0;
        issue_regwrite_i = 1'b0;
        issue_regdst_i   = 1'b0;
        issue_rs_i       = '0;
        issue_rt_i       = '0;
        issue_rd_i       = '0;
        issue_lat_i      = '0;
        flush_i          = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        rst_i = 1'b0;
        idle_inputs();
        tick();
        tick();
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        tick();
    endtask

    task automatic set_instr(input int rs, input int rt, input int rd, input bit use_rs,
                             input bit use_rt, input bit regdst, input bit regwrite, input int lat);
        issue_rs_i       = ADDR_W'(rs);
        issue_rt_i       = ADDR_W'(rt);
        issue_rd_i       = ADDR_W'(rd);
        issue_use_rs_i   = use_rs;
        issue_use_rt_i   = use_rt;
        issue_regdst_i   = regdst;
        issue_regwrite_i = regwrite;
        issue_lat_i      = LAT_W'(lat);
        issue_valid_i    = 1'b1;
    endtask

    // Offer one instruction until accepted; returns at the cycle after accept.
    task automatic issue(input int rs, input int rt, input int rd, input bit use_rs,
                         input bit use_rt, input bit regdst, input bit regwrite,
                         input int lat, output int stalls);
        set_instr(rs, rt, rd, use_rs, use_rt, regdst, regwrite, lat);
        stalls = 0;
        @(negedge clk_i);
        while (!issue_ready_o && stalls < 20) begin
            stalls++;
            @(negedge clk_i);
        end
        if (!issue_ready_o) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout: got ready=0 after %0d cycles expected accept", stalls);
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        idle_inputs();
        tick();
        tick();
        mon_en = 1'b1;
        do_reset();

        // 1: basic Rd write, L=3
        @(negedge clk_i);
        check("t1_reset_wb_valid", wb_valid_o, 0);
        check("t1_reset_wb_dest", wb_dest_o, 0);
        check("t1_reset_stall", stall_cnt_o, 0);
        tick();
        set_instr(0, 2, 5, 0, 0, 1, 1, 3);
        @(negedge clk_i);
        check("t1_ready", issue_ready_o, 1);
        check("t1_dest", dest_o, 5);
        tick();
        idle_inputs();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk_i);
            check("t1_wb_valid", wb_valid_o, i == 3);
            if (i == 3) check("t1_wb_dest", wb_dest_o, 5);
        end

        // 2: RAW on r7, L=2 then L=3
        do_reset();
        issue(0, 0, 7, 0, 0, 1, 1, 2, s);
        issue(7, 0, 0, 1, 0, 0, 0, 1, s);
        check("t2a_stalls", s, 1);
        @(negedge clk_i);
        check("t2a_stall_cnt", stall_cnt_o, 1);
        do_reset();
        issue(0, 0, 7, 0, 0, 1, 1, 3, s);
        issue(0, 7, 0, 0, 1, 0, 0, 1, s);
        check("t2b_stalls", s, 2);
        @(negedge clk_i);
        check("t2b_stall_cnt", stall_cnt_o, 2);

        // 3: write-port conflict, r3 L=4 then r4 L=3
        do_reset();
        issue(0, 0, 3, 0, 0, 1, 1, 4, s);
        issue(0, 4, 0, 0, 0, 0, 1, 3, s);
        check("t3_stalls", s, 1);
        for (int i = 3; i <= 6; i++) begin
            @(negedge clk_i);
            check("t3_wb_valid", wb_valid_o, (i == 4) || (i == 5));
            if (i == 4) check("t3_wb_dest_first", wb_dest_o, 3);
            if (i == 5) check("t3_wb_dest_second", wb_dest_o, 4);
        end

        // 4: WAW on r9
        do_reset();
        issue(0, 0, 9, 0, 0, 1, 1, 4, s);
        issue(0, 0, 9, 0, 0, 1, 1, 1, s);
        check("t4_stalls", s, 3);
        @(negedge clk_i);
        check("t4_wb_valid", wb_valid_o, 1);
        check("t4_wb_dest", wb_dest_o, 9);
        @(negedge clk_i);
        check("t4_wb_after", wb_valid_o, 0);

        // 5: dest 0, regwrite=0, lat=0, lat above MAX_LAT
        do_reset();
        issue(0, 0, 0, 0, 0, 1, 1, 2, s);
        @(negedge clk_i);
        check("t5_dest0_busy", busy_o, 0);
        tick();
        issue(0, 0, 6, 0, 0, 1, 0, 2, s);
        @(negedge clk_i);
        check("t5_nowrite_busy", busy_o, 0);
        tick();
        issue(0, 0, 8, 0, 0, 1, 1, 0, s);
        @(negedge clk_i);
        check("t5_lat0_wb_valid", wb_valid_o, 1);
        check("t5_lat0_wb_dest", wb_dest_o, 8);
        tick();
        issue(0, 0, 12, 0, 0, 1, 1, 7, s);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk_i);
            check("t5_clamp_wb_valid", wb_valid_o, i == 4);
        end

        // 6a: flush with three pending writes, r10 in slot 0
        do_reset();
        issue(0, 0, 10, 0, 0, 1, 1, 4, s);
        issue(0, 0, 11, 0, 0, 1, 1, 4, s);
        issue(0, 0, 12, 0, 0, 1, 1, 4, s);
        tick();
        set_instr(0, 0, 13, 0, 0, 1, 1, 1);
        flush_i = 1'b1;
        @(negedge clk_i);
        check("t6_flush_ready", issue_ready_o, 0);
        check("t6_flush_wb_valid", wb_valid_o, 1);
        check("t6_flush_wb_dest", wb_dest_o, 10);
        tick();
        idle_inputs();
        @(negedge clk_i);
        check("t6_after_wb_valid", wb_valid_o, 0);
        check("t6_after_busy", busy_o, 0);
        check("t6_after_stall", stall_cnt_o, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("t6_quiet_wb_valid", wb_valid_o, 0);
        end

        // 6b: async reset mid-flight
        do_reset();
        issue(0, 0, 10, 0, 0, 1, 1, 4, s);
        issue(0, 0, 11, 0, 0, 1, 1, 4, s);
        issue(0, 0, 12, 0, 0, 1, 1, 4, s);
        check("t6b_busy_before", busy_o, 1);
        #3 rst_i = 1'b0;
        #1;
        check("t6b_rst_wb_valid", wb_valid_o, 0);
        check("t6b_rst_busy", busy_o, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("t6b_quiet_wb_valid", wb_valid_o, 0);
        end

        // 7: stall counter saturation under a held flush
        do_reset();
        set_instr(0, 0, 0, 0, 0, 0, 0, 1);
        flush_i = 1'b1;
        repeat (20) tick();
        idle_inputs();
        @(negedge clk_i);
        check("t7_stall_sat", stall_cnt_o, CNT_MAX);

        tick();
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
